// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//
// SPI (mode 0) slave that writes five 8-bit control registers. The SPI pins
// are asynchronous to clk and are oversampled: each passes through a 2-flop
// synchronizer plus one history flop, and every edge is detected from the
// synchronized/history pair only.
//
// Frame: 16 bits, MSB first. bit 15 = R/W (1 = write), bits 14..8 = address,
// bits 7..0 = data. A write commits on the ncs rising edge only when exactly
// 16 bits were received, R/W = 1 and the address is 0x00..0x04.
//
// Optional feature (macro SPI_READBACK_EN): R/W = 0 frames return the
// addressed register on cipo during bits 9..16. Without the macro, cipo is
// tied low.
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   sclk, copi, ncs  SPI inputs (asynchronous to clk)
//   cipo             SPI data out (0 when readback is not active)
//   en_reg_out_7_0   register 0x00
//   en_reg_out_15_8  register 0x01
//   en_reg_pwm_7_0   register 0x02
//   en_reg_pwm_15_8  register 0x03
//   pwm_duty_cycle   register 0x04
// ---------------------------------------------------------------------------
module spi_reg_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle
);

  // ST_ARM   : after reset, waiting to see ncs high before any frame may open
  // ST_IDLE  : ncs high (or low but no falling edge seen yet)
  // ST_ACTIVE: frame open, collecting bits
  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // -------------------------------------------------------------------------
  // Input synchronizers and history flops
  // -------------------------------------------------------------------------
  logic [1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic       sclk_hist_q, copi_hist_q, ncs_hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= 2'b00;
      sclk_hist_q <= 1'b0;
      copi_sync_q <= 2'b00;
      copi_hist_q <= 1'b0;
      ncs_sync_q  <= 2'b11;
      ncs_hist_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      sclk_hist_q <= sclk_sync_q[1];
      copi_sync_q <= {copi_sync_q[0], copi};
      copi_hist_q <= copi_sync_q[1];
      ncs_sync_q  <= {ncs_sync_q[0], ncs};
      ncs_hist_q  <= ncs_sync_q[1];
    end
  end

  logic sclk_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise;

  assign sclk_s    = sclk_sync_q[1];
  assign ncs_s     = ncs_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_fall  = ~ncs_s & ncs_hist_q;
  assign ncs_rise  = ncs_s & ~ncs_hist_q;

  // The synchronizer still holds its reset value of ncs = 1 for two cycles
  // after reset. Arming waits until the pipeline has refilled with real
  // samples, so an ncs held low through reset never looks like a fall.
  logic [1:0] prime_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_q <= 2'd0;
    end else if (prime_q != 2'd2) begin
      prime_q <= prime_q + 2'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Frame FSM: state register / next state / outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ARM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARM:    if ((prime_q == 2'd2) && ncs_s) state_d = ST_IDLE;
      ST_IDLE:   if (ncs_fall)                   state_d = ST_ACTIVE;
      ST_ACTIVE: if (ncs_rise)                   state_d = ST_IDLE;
      default:                                   state_d = ST_ARM;
    endcase
  end

  logic frame_active, frame_start;

  always_comb begin
    frame_active = (state_q == ST_ACTIVE);
    frame_start  = (state_q == ST_IDLE) && ncs_fall;
  end

  // -------------------------------------------------------------------------
  // Bit collection
  // -------------------------------------------------------------------------
  logic [4:0]  bit_cnt_q;
  logic [15:0] shift_q;
  logic        shift_en;

  assign shift_en = frame_active & ~ncs_s & sclk_rise;

  // Counter saturates at 17 so any overlong frame stays distinguishable
  // from a 16-bit one; bits past the 16th are not shifted in.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q <= 5'd0;
      shift_q   <= 16'h0000;
    end else if (frame_start) begin
      bit_cnt_q <= 5'd0;
      shift_q   <= 16'h0000;
    end else if (shift_en) begin
      if (bit_cnt_q < 5'd16) shift_q <= {shift_q[14:0], copi_hist_q};
      if (bit_cnt_q != 5'd17) bit_cnt_q <= bit_cnt_q + 5'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic       commit;
  logic [7:0] out_lo_q, out_hi_q, pwm_lo_q, pwm_hi_q, duty_q;
  logic [7:0] out_lo_d, out_hi_d, pwm_lo_d, pwm_hi_d, duty_d;

  assign commit = frame_active & ncs_rise & (bit_cnt_q == 5'd16) &
                  shift_q[15] & (shift_q[14:8] <= 7'd4);

  always_comb begin
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    pwm_lo_d = pwm_lo_q;
    pwm_hi_d = pwm_hi_q;
    duty_d   = duty_q;
    if (commit) begin
      case (shift_q[10:8])
        3'd0:    out_lo_d = shift_q[7:0];
        3'd1:    out_hi_d = shift_q[7:0];
        3'd2:    pwm_lo_d = shift_q[7:0];
        3'd3:    pwm_hi_d = shift_q[7:0];
        3'd4:    duty_d   = shift_q[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_lo_q <= 8'h00;
      out_hi_q <= 8'h00;
      pwm_lo_q <= 8'h00;
      pwm_hi_q <= 8'h00;
      duty_q   <= 8'h00;
    end else begin
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      pwm_lo_q <= pwm_lo_d;
      pwm_hi_q <= pwm_hi_d;
      duty_q   <= duty_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;

  // -------------------------------------------------------------------------
  // Readback
  // -------------------------------------------------------------------------
`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic       rd_load;
  logic [6:0] rd_addr;
  logic [7:0] rd_val;
  logic       cipo_q;
  logic       rd_active_q;
  logic [6:0] rd_shift_q;
  logic [3:0] rd_cnt_q;

  assign sclk_fall = ~sclk_s & sclk_hist_q;

  // On the 8th rising edge the shift register holds R/W and address bits
  // 14..9; the incoming bit is address bit 8.
  assign rd_addr = {shift_q[5:0], copi_hist_q};
  assign rd_load = shift_en & (bit_cnt_q == 5'd7) & ~shift_q[6];

  always_comb begin
    rd_val = 8'h00;
    case (rd_addr)
      7'd0:    rd_val = out_lo_q;
      7'd1:    rd_val = out_hi_q;
      7'd2:    rd_val = pwm_lo_q;
      7'd3:    rd_val = pwm_hi_q;
      7'd4:    rd_val = duty_q;
      default: rd_val = 8'h00;
    endcase
  end

  // Bit 7 goes out at the 8th rising edge. The falling edge right after it
  // precedes the controller's 9th sample, so it holds bit 7; the next seven
  // falls shift bits 6..0, and the one after that ends the readback.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cipo_q      <= 1'b0;
      rd_active_q <= 1'b0;
      rd_shift_q  <= 7'd0;
      rd_cnt_q    <= 4'd0;
    end else if (!frame_active) begin
      cipo_q      <= 1'b0;
      rd_active_q <= 1'b0;
      rd_shift_q  <= 7'd0;
      rd_cnt_q    <= 4'd0;
    end else if (rd_load) begin
      cipo_q      <= rd_val[7];
      rd_shift_q  <= rd_val[6:0];
      rd_active_q <= 1'b1;
      rd_cnt_q    <= 4'd0;
    end else if (rd_active_q && sclk_fall && !ncs_s) begin
      if (rd_cnt_q == 4'd0) begin
        rd_cnt_q <= 4'd1;
      end else if (rd_cnt_q < 4'd8) begin
        cipo_q     <= rd_shift_q[6];
        rd_shift_q <= {rd_shift_q[5:0], 1'b0};
        rd_cnt_q   <= rd_cnt_q + 4'd1;
      end else begin
        cipo_q      <= 1'b0;
        rd_active_q <= 1'b0;
      end
    end
  end

  assign cipo = cipo_q;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port sclk, input, 1, SPI serial clock; asynchronous to clk, frequency at most clk/6.
REQ-004 SHALL have port copi, input, 1, SPI controller-out data; asynchronous.
REQ-005 SHALL have port ncs, input, 1, SPI chip select, active low; asynchronous.
REQ-006 SHALL have port cipo, output, 1, SPI controller-in data.
REQ-007 SHALL have port en_reg_out_7_0, output, 8, output enables for channels 7..0 (address 0x00).
REQ-008 SHALL have port en_reg_out_15_8, output, 8, output enables for channels 15..8 (address 0x01).
REQ-009 SHALL have port en_reg_pwm_7_0, output, 8, PWM mode select for channels 7..0 (address 0x02).
REQ-010 SHALL have port en_reg_pwm_15_8, output, 8, PWM mode select for channels 15..8 (address 0x03).
REQ-011 SHALL have port pwm_duty_cycle, output, 8, shared PWM duty value (address 0x04).

Function
REQ-012 SHALL pass sclk, copi and ncs each through a 2-flop synchronizer plus one history flop; all edge detection uses the synchronized and history stages only.
REQ-013 SHALL use SPI mode 0: copi sampled on each detected sclk rising edge; cipo changed on detected sclk falling edges.
REQ-014 SHALL open a frame only on a detected ncs falling edge; ncs already low when rst_n deasserts opens no frame until ncs goes high then low again.
REQ-015 SHALL define a frame as 16 bits MSB first: bit 15 = R/W (1 = write, 0 = read), bits 14..8 = address, bits 7..0 = data.
REQ-016 SHALL count received bits with a 5-bit counter that saturates at 17; bits arriving beyond 16 are not shifted in.
REQ-017 SHALL commit a write only on a detected ncs rising edge with bit count exactly 16, R/W = 1 and address 0x00..0x04; the target output updates on the same clk edge that registers the ncs rising edge detection, i.e. the 3rd clk rising edge after ncs is first sampled high.
REQ-018 SHALL discard, with no register change, frames with fewer or more than 16 bits, addresses 0x05..0x7F, and R/W = 0 frames.
REQ-019 SHALL hold all five registers unchanged between commits; at most one register changes per frame.
REQ-020 SHALL treat an ncs falling edge and an ncs rising edge in successive synchronized samples as an empty frame, with no change.
REQ-021 SHALL ignore sclk edges while ncs (synchronized) is high.
REQ-022 SHALL hold cipo low whenever readback is not active, including while ncs is high.

Reset
REQ-023 SHALL, when rst_n is sampled low, clear all five register outputs to 0x00, cipo to 0, the bit counter, the shift register and the frame-active flag.
REQ-024 SHALL initialize synchronizer and history flops to sclk = 0, copi = 0 and ncs = 1 on reset, so that no edge is detected on the first cycle after reset.
REQ-025 SHALL abandon a frame in progress when rst_n is asserted mid-frame, with no commit even if ncs later rises after 16 bits.

Configuration
REQ-026 SHALL compile readback logic only when macro SPI_READBACK_EN is defined.
REQ-027 SHALL, with SPI_READBACK_EN defined and R/W = 0, load cipo with bit 7 of the addressed register on the clk edge registering the 8th sclk rising edge. It SHALL then shift the next bit out on each of the following 7 detected sclk falling edges. Addresses 0x05..0x7F SHALL read 0x00.
REQ-028 SHALL, without SPI_READBACK_EN, tie cipo constantly to 0; write behaviour is identical in both builds.

Verification
REQ-029 SHALL cover: reset, then write frame 0x80 0xA5 -> en_reg_out_7_0 = 0xA5; all other outputs remain 0x00.
REQ-030 SHALL cover: write frame 0x84 0x80 -> pwm_duty_cycle = 0x80 exactly 3 clk edges after ncs is sampled high.
REQ-031 SHALL cover: 15-bit frame and 17-bit frame targeting 0x81 -> en_reg_out_15_8 stays 0x00.
REQ-032 SHALL cover: write 0x85 0xFF (invalid address) and read frame 0x02 0x00 in the build without the macro -> no register change, cipo constant 0.
REQ-033 SHALL cover, with SPI_READBACK_EN: write 0x83 0x3C, then read frame 0x03 0x00 -> cipo presents 0,0,1,1,1,1,0,0 on sclk rising edges 9..16; en_reg_pwm_15_8 stays 0x3C.
REQ-034 SHALL cover: rst_n pulsed low after 10 bits of frame 0x82 0x55, ncs held low and the remaining bits clocked -> en_reg_pwm_7_0 = 0x00.
